// File: rtl/apb_cmd_master.sv
// APB initiator: valid/ready command stream in, APB transfer out, valid/ready response back.
// Latency: accept->RSP_VALID 3 cycles (zero-wait), +1 per wait state, decode error 1 cycle.
// Backpressure: one transfer outstanding; CMD_READY low until the response handshake completes.
//
// Ports:
//   PCLK, PRESETn                 clock, synchronous active-low reset
//   CMD_*                         command stream (VALID/READY, WRITE, ADDR, WDATA, STRB, PROT)
//   RSP_*                         response stream (VALID/READY, RDATA, ERR: 0 ok/1 slverr/2 decode/3 timeout)
//   PSEL..PPROT                   shared APB request signals, one-hot PSEL per slave
//   PRDATA, PREADY, PSLVERR       per-slave APB return signals, slave n at slice n
module apb_cmd_master #(
    parameter int P_NUM       = 4,
    parameter int P_SLV_SHIFT = 10,
    parameter int P_TIMEOUT   = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic                  CMD_WRITE,
    input  logic [31:0]           CMD_ADDR,
    input  logic [31:0]           CMD_WDATA,
    input  logic [3:0]            CMD_STRB,
    input  logic [2:0]            CMD_PROT,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [31:0]           RSP_RDATA,
    output logic [1:0]            RSP_ERR,
    output logic [P_NUM-1:0]      PSEL,
    output logic                  PENABLE,
    output logic [31:0]           PADDR,
    output logic                  PWRITE,
    output logic [31:0]           PWDATA,
    output logic [3:0]            PSTRB,
    output logic [2:0]            PPROT,
    input  logic [32*P_NUM-1:0]   PRDATA,
    input  logic [P_NUM-1:0]      PREADY,
    input  logic [P_NUM-1:0]      PSLVERR
);

    localparam int IDX_W = (P_NUM > 1) ? $clog2(P_NUM) : 1;
    localparam int CNT_W = $clog2(P_TIMEOUT + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_SLV     = 2'd1;
    localparam logic [1:0] ERR_DECODE  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    logic [1:0]        state;
    logic [IDX_W-1:0]  idx;        // slave of the transfer in flight
    logic [CNT_W-1:0]  wait_cnt;   // ACCESS cycles already spent without PREADY

    logic [31:0]       addr_slot;
    logic              decode_ok;
    logic [IDX_W-1:0]  cmd_idx;
    logic [P_NUM-1:0]  cmd_sel;
    logic              sel_ready;
    logic              sel_err;
    logic [31:0]       sel_rdata;

    // Slave decode of the incoming command and mux of the selected slave's return path.
    // Unselected slaves' PREADY/PSLVERR/PRDATA never reach the FSM.
    always_comb begin
        addr_slot = CMD_ADDR >> P_SLV_SHIFT;
        decode_ok = (addr_slot < 32'(P_NUM));
        cmd_idx   = addr_slot[IDX_W-1:0];
        cmd_sel   = '0;
        for (int i = 0; i < P_NUM; i++) begin
            if (cmd_idx == IDX_W'(i)) begin
                cmd_sel[i] = 1'b1;
            end
        end
        sel_ready = PREADY[idx];
        sel_err   = PSLVERR[idx];
        sel_rdata = PRDATA[32*idx +: 32];
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state     <= S_IDLE;
            idx       <= '0;
            wait_cnt  <= '0;
            CMD_READY <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_RDATA <= '0;
            RSP_ERR   <= ERR_OK;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            PSTRB     <= '0;
            PPROT     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Also raises CMD_READY on the first cycle out of reset.
                    CMD_READY <= 1'b1;
                    if (CMD_VALID && CMD_READY) begin
                        CMD_READY <= 1'b0;
                        if (!decode_ok) begin
                            // No APB cycle; bus request signals keep their last values.
                            RSP_VALID <= 1'b1;
                            RSP_ERR   <= ERR_DECODE;
                            RSP_RDATA <= '0;
                            state     <= S_RESP;
                        end else begin
                            idx    <= cmd_idx;
                            PSEL   <= cmd_sel;
                            PADDR  <= CMD_ADDR;
                            PWRITE <= CMD_WRITE;
                            PPROT  <= CMD_PROT;
                            PWDATA <= CMD_WRITE ? CMD_WDATA : 32'h0;
                            PSTRB  <= CMD_WRITE ? CMD_STRB  : 4'h0;
                            state  <= S_SETUP;
                        end
                    end
                end

                S_SETUP: begin
                    PENABLE  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= S_ACCESS;
                end

                S_ACCESS: begin
                    // PREADY is checked before the timeout so a slave answering on the
                    // last allowed cycle still completes normally.
                    if (sel_ready) begin
                        PSEL      <= '0;
                        PENABLE   <= 1'b0;
                        RSP_VALID <= 1'b1;
                        RSP_ERR   <= sel_err ? ERR_SLV : ERR_OK;
                        RSP_RDATA <= (!PWRITE && !sel_err) ? sel_rdata : 32'h0;
                        state     <= S_RESP;
                    end else if (wait_cnt == CNT_W'(P_TIMEOUT - 1)) begin
                        PSEL      <= '0;
                        PENABLE   <= 1'b0;
                        RSP_VALID <= 1'b1;
                        RSP_ERR   <= ERR_TIMEOUT;
                        RSP_RDATA <= '0;
                        state     <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                S_RESP: begin
                    if (RSP_READY) begin
                        RSP_VALID <= 1'b0;
                        CMD_READY <= 1'b1;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with four behavioural APB memory slaves.
// Latency: n/a (bench); per-transfer latencies are measured in cycles after the accept edge.
// Backpressure: RSP_READY is held low for a programmable number of cycles per command.
module tb_apb_cmd_master;

    logic         PCLK;
    logic         PRESETn;
    logic         CMD_VALID;
    logic         CMD_READY;
    logic         CMD_WRITE;
    logic [31:0]  CMD_ADDR;
    logic [31:0]  CMD_WDATA;
    logic [3:0]   CMD_STRB;
    logic [2:0]   CMD_PROT;
    logic         RSP_VALID;
    logic         RSP_READY;
    logic [31:0]  RSP_RDATA;
    logic [1:0]   RSP_ERR;
    logic [3:0]   PSEL;
    logic         PENABLE;
    logic [31:0]  PADDR;
    logic         PWRITE;
    logic [31:0]  PWDATA;
    logic [3:0]   PSTRB;
    logic [2:0]   PPROT;
    logic [127:0] PRDATA;
    logic [3:0]   PREADY;
    logic [3:0]   PSLVERR;

    int n_chk  = 0;
    int n_fail = 0;

    apb_cmd_master #(.P_NUM(4), .P_SLV_SHIFT(10), .P_TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
        .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_STRB(CMD_STRB), .CMD_PROT(CMD_PROT),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PSTRB(PSTRB), .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Slave models: per-slave wait count, error and hang knobs. Unselected slaves
    // drive PREADY=1 and PSLVERR=1 so any leakage into the master shows up.
    logic [31:0] mem [4][256];
    int          wait_cfg [4];
    logic        err_cfg  [4];
    logic        hang     [4];
    int          wcnt     [4];
    logic [3:0]  rdy_sel;

    always_comb begin
        rdy_sel = '0;
        PREADY  = '0;
        PSLVERR = '0;
        PRDATA  = '0;
        for (int i = 0; i < 4; i++) begin
            rdy_sel[i] = PSEL[i] && PENABLE && !hang[i] && (wcnt[i] >= wait_cfg[i]);
            if (PSEL[i]) begin
                PREADY[i]  = rdy_sel[i];
                PSLVERR[i] = rdy_sel[i] && err_cfg[i];
            end else begin
                PREADY[i]  = 1'b1;
                PSLVERR[i] = 1'b1;
            end
            PRDATA[32*i +: 32] = mem[i][PADDR[9:2]];
        end
    end

    always @(posedge PCLK) begin
        for (int i = 0; i < 4; i++) begin
            if (PSEL[i] && PENABLE && !rdy_sel[i]) wcnt[i] <= wcnt[i] + 1;
            else                                   wcnt[i] <= 0;
            if (rdy_sel[i] && PWRITE && !err_cfg[i]) begin
                for (int b = 0; b < 4; b++) begin
                    if (PSTRB[b]) mem[i][PADDR[9:2]][8*b +: 8] <= PWDATA[8*b +: 8];
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
        int          lat;
        logic [3:0]  psel;
        int          pen;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] addr;
        logic [2:0]  prot;
    } res_t;

    // Issue one command, observe the APB phase, then hold RSP_READY low for `hold` cycles.
    task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [2:0] prot, input int hold,
                          output res_t r);
        logic acc;
        logic got;
        r = '{rdata: 32'h0, err: 2'd0, lat: 0, psel: 4'h0, pen: 0, strb: 4'h0,
              wdata: 32'h0, addr: 32'h0, prot: 3'h0};
        CMD_VALID = 1'b1; CMD_WRITE = wr; CMD_ADDR = addr;
        CMD_WDATA = wdata; CMD_STRB = strb; CMD_PROT = prot;
        acc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (CMD_READY === 1'b1) begin acc = 1'b1; break; end
            @(negedge PCLK);
        end
        check_eq("cmd_accepted", 32'(acc), 32'd1);
        @(posedge PCLK);
        @(negedge PCLK);
        CMD_VALID = 1'b0;
        r.lat = 1;
        got = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (RSP_VALID === 1'b1) begin got = 1'b1; break; end
            if (PSEL != 4'h0) begin
                r.psel  = r.psel | PSEL;
                r.strb  = PSTRB;
                r.wdata = PWDATA;
                r.addr  = PADDR;
                r.prot  = PPROT;
            end
            if (PENABLE) r.pen++;
            @(negedge PCLK);
            r.lat++;
        end
        check_eq("rsp_seen", 32'(got), 32'd1);
        r.rdata = RSP_RDATA;
        r.err   = RSP_ERR;
        for (int h = 0; h < hold; h++) begin
            check_eq("hold_rsp_valid", 32'(RSP_VALID), 32'd1);
            check_eq("hold_rsp_rdata", RSP_RDATA, r.rdata);
            check_eq("hold_rsp_err",   32'(RSP_ERR), 32'(r.err));
            check_eq("hold_cmd_ready", 32'(CMD_READY), 32'd0);
            check_eq("hold_no_psel",   32'(PSEL), 32'd0);
            @(negedge PCLK);
        end
        RSP_READY = 1'b1;
        @(negedge PCLK);
        RSP_READY = 1'b0;
        check_eq("rsp_dropped",    32'(RSP_VALID), 32'd0);
        check_eq("cmd_ready_back", 32'(CMD_READY), 32'd1);
    endtask

    res_t r;
    logic seen;

    initial begin
        PRESETn = 1'b0; CMD_VALID = 1'b0; CMD_WRITE = 1'b0; CMD_ADDR = '0;
        CMD_WDATA = '0; CMD_STRB = '0; CMD_PROT = '0; RSP_READY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_cfg[i] = 0; err_cfg[i] = 1'b0; hang[i] = 1'b0;
        end

        // Reset state
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        check_eq("rst_cmd_ready", 32'(CMD_READY), 32'd0);
        check_eq("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
        check_eq("rst_rsp_rdata", RSP_RDATA, 32'd0);
        check_eq("rst_rsp_err",   32'(RSP_ERR), 32'd0);
        check_eq("rst_psel",      32'(PSEL), 32'd0);
        check_eq("rst_penable",   32'(PENABLE), 32'd0);
        check_eq("rst_paddr",     PADDR, 32'd0);
        check_eq("rst_pwrite",    32'(PWRITE), 32'd0);
        check_eq("rst_pwdata",    PWDATA, 32'd0);
        check_eq("rst_pstrb",     32'(PSTRB), 32'd0);
        check_eq("rst_pprot",     32'(PPROT), 32'd0);
        PRESETn = 1'b1;
        @(negedge PCLK);
        check_eq("rel_cmd_ready", 32'(CMD_READY), 32'd1);

        // Write then read slave 1
        do_cmd(1'b1, 32'h0000_0404, 32'hA5A5_1234, 4'hF, 3'b010, 0, r);
        check_eq("wr1_psel",  32'(r.psel), 32'h2);
        check_eq("wr1_lat",   32'(r.lat), 32'd3);
        check_eq("wr1_err",   32'(r.err), 32'd0);
        check_eq("wr1_rdata", r.rdata, 32'h0);
        check_eq("wr1_pen",   32'(r.pen), 32'd1);
        check_eq("wr1_pstrb", 32'(r.strb), 32'hF);
        check_eq("wr1_pwdata", r.wdata, 32'hA5A5_1234);
        check_eq("wr1_paddr", r.addr, 32'h0000_0404);
        check_eq("wr1_pprot", 32'(r.prot), 32'h2);

        // Read with 5 cycles of response backpressure; read strobes/data must be zero
        do_cmd(1'b0, 32'h0000_0404, 32'hDEAD_BEEF, 4'hF, 3'b001, 5, r);
        check_eq("rd1_psel",   32'(r.psel), 32'h2);
        check_eq("rd1_lat",    32'(r.lat), 32'd3);
        check_eq("rd1_err",    32'(r.err), 32'd0);
        check_eq("rd1_rdata",  r.rdata, 32'hA5A5_1234);
        check_eq("rd1_pstrb",  32'(r.strb), 32'h0);
        check_eq("rd1_pwdata", r.wdata, 32'h0);
        check_eq("rd1_pprot",  32'(r.prot), 32'h1);
        check_eq("idle_paddr_hold",  PADDR, 32'h0000_0404);
        check_eq("idle_pprot_hold",  32'(PPROT), 32'h1);

        // Partial strobes: bytes 0 and 2 only
        do_cmd(1'b1, 32'h0000_0404, 32'hFFFF_FFFF, 4'b0101, 3'b000, 0, r);
        do_cmd(1'b0, 32'h0000_0404, 32'h0, 4'h0, 3'b000, 0, r);
        check_eq("strb_rdata", r.rdata, 32'hA5FF_12FF);

        // Slave 2: three wait states
        do_cmd(1'b1, 32'h0000_0800, 32'h2222_0800, 4'hF, 3'b000, 0, r);
        wait_cfg[2] = 3;
        do_cmd(1'b0, 32'h0000_0800, 32'h0, 4'h0, 3'b000, 0, r);
        check_eq("ws_psel",  32'(r.psel), 32'h4);
        check_eq("ws_pen",   32'(r.pen), 32'd4);
        check_eq("ws_lat",   32'(r.lat), 32'd6);
        check_eq("ws_rdata", r.rdata, 32'h2222_0800);
        check_eq("ws_err",   32'(r.err), 32'd0);
        wait_cfg[2] = 0;

        // Slave 3: PSLVERR on read
        err_cfg[3] = 1'b1;
        do_cmd(1'b0, 32'h0000_0C00, 32'h0, 4'h0, 3'b000, 0, r);
        check_eq("se_psel",  32'(r.psel), 32'h8);
        check_eq("se_err",   32'(r.err), 32'd1);
        check_eq("se_rdata", r.rdata, 32'h0);
        check_eq("se_lat",   32'(r.lat), 32'd3);
        err_cfg[3] = 1'b0;

        // Slave 0: never ready -> timeout after 16 ACCESS cycles
        hang[0] = 1'b1;
        do_cmd(1'b0, 32'h0000_0000, 32'h0, 4'h0, 3'b000, 0, r);
        check_eq("to_psel",  32'(r.psel), 32'h1);
        check_eq("to_pen",   32'(r.pen), 32'd16);
        check_eq("to_lat",   32'(r.lat), 32'd18);
        check_eq("to_err",   32'(r.err), 32'd3);
        check_eq("to_rdata", r.rdata, 32'h0);
        check_eq("to_psel_after", 32'(PSEL), 32'd0);
        hang[0] = 1'b0;

        // Slave 0: PREADY on the 16th ACCESS cycle completes normally
        do_cmd(1'b1, 32'h0000_0010, 32'h0000_0F0F, 4'hF, 3'b000, 0, r);
        wait_cfg[0] = 15;
        do_cmd(1'b0, 32'h0000_0010, 32'h0, 4'h0, 3'b000, 0, r);
        check_eq("last_pen",   32'(r.pen), 32'd16);
        check_eq("last_lat",   32'(r.lat), 32'd18);
        check_eq("last_err",   32'(r.err), 32'd0);
        check_eq("last_rdata", r.rdata, 32'h0000_0F0F);
        wait_cfg[0] = 0;

        // Decode error (idx 4) with 5 cycles of backpressure
        do_cmd(1'b0, 32'h0000_1000, 32'h0, 4'h0, 3'b000, 5, r);
        check_eq("dec_psel",  32'(r.psel), 32'h0);
        check_eq("dec_pen",   32'(r.pen), 32'd0);
        check_eq("dec_lat",   32'(r.lat), 32'd1);
        check_eq("dec_err",   32'(r.err), 32'd2);
        check_eq("dec_rdata", r.rdata, 32'h0);
        check_eq("dec_paddr_hold", PADDR, 32'h0000_0010);

        // Reset during ACCESS aborts the transfer
        hang[1] = 1'b1;
        CMD_VALID = 1'b1; CMD_WRITE = 1'b0; CMD_ADDR = 32'h0000_0400;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (PENABLE === 1'b1) begin seen = 1'b1; break; end
            @(negedge PCLK);
            if (CMD_READY !== 1'b1) CMD_VALID = 1'b0;
        end
        CMD_VALID = 1'b0;
        check_eq("mr_access_seen", 32'(seen), 32'd1);
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b0;
        @(posedge PCLK);
        #1;
        check_eq("mr_psel",      32'(PSEL), 32'd0);
        check_eq("mr_penable",   32'(PENABLE), 32'd0);
        check_eq("mr_rsp_valid", 32'(RSP_VALID), 32'd0);
        check_eq("mr_cmd_ready", 32'(CMD_READY), 32'd0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        hang[1] = 1'b0;
        repeat (4) @(negedge PCLK);
        check_eq("mr_no_rsp",    32'(RSP_VALID), 32'd0);
        check_eq("mr_cmd_ready_after", 32'(CMD_READY), 32'd1);

        do_cmd(1'b1, 32'h0000_0C08, 32'h1234_5678, 4'hF, 3'b100, 0, r);
        check_eq("post_wr_psel", 32'(r.psel), 32'h8);
        check_eq("post_wr_lat",  32'(r.lat), 32'd3);
        check_eq("post_wr_err",  32'(r.err), 32'd0);
        do_cmd(1'b0, 32'h0000_0C08, 32'h0, 4'h0, 3'b000, 0, r);
        check_eq("post_rd_rdata", r.rdata, 32'h1234_5678);
        check_eq("post_rd_err",   32'(r.err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
